// File: rtl/greycode_burst_arbiter_pkg.sv
// ============================================================================
// Module : greycode_pkg
// Brief  : Shared types and Gray-code helpers for greycode_burst_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package greycode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int c_gray_max_w = 32;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [c_gray_max_w-1:0] gray2bin(input logic [c_gray_max_w-1:0] g);
    logic [c_gray_max_w-1:0] b;
    b[c_gray_max_w-1] = g[c_gray_max_w-1];
    for (int i = c_gray_max_w - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Increment in the binary domain and re-encode, so the result wraps at 2^width.
  function automatic logic [c_gray_max_w-1:0] gray_next(input logic [c_gray_max_w-1:0] g,
                                                        input int width);
    logic [c_gray_max_w-1:0] b;
    logic [c_gray_max_w-1:0] mask;
    mask = (width >= c_gray_max_w) ? '1 : ((32'd1 << width) - 32'd1);
    b    = (gray2bin(g) + 32'd1) & mask;
    return b ^ (b >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/greycode_burst_arbiter_if.sv
// ============================================================================
// Module : greycode_burst_arbiter_if
// Brief  : Request/grant and streaming bus of the Gray burst arbiter.
//          bin_out exists only when GREYCODE_ARB_BIN_OUT_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface greycode_burst_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int LEN_W = 10
) ();
  localparam int ID_W = greycode_pkg::id_width(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [WIDTH-1:0]      grey_out;
  logic [ID_W-1:0]       out_id;
  logic                  out_valid;
  logic                  out_ready;
  logic                  done;
`ifdef GREYCODE_ARB_BIN_OUT_EN
  logic [WIDTH-1:0]      bin_out;

  modport slave  (input req, req_len, out_ready,
                  output gnt, busy, grey_out, out_id, out_valid, done, bin_out);
  modport master (output req, req_len, out_ready,
                  input gnt, busy, grey_out, out_id, out_valid, done, bin_out);
`else
  modport slave  (input req, req_len, out_ready,
                  output gnt, busy, grey_out, out_id, out_valid, done);
  modport master (output req, req_len, out_ready,
                  input gnt, busy, grey_out, out_id, out_valid, done);
`endif

endinterface

`default_nettype wire

// File: rtl/greycode_burst_arbiter_rr.sv
// ============================================================================
// Module : greycode_rr_arbiter
// Brief  : Combinational round-robin pick: first set request at or after ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module greycode_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_winner,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);

  always_comb begin
    o_winner = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = int'(i_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!o_any && i_req[j]) begin
        o_any       = 1'b1;
        o_winner[j] = 1'b1;
        o_idx       = ID_W'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/greycode_burst_arbiter.sv
// ============================================================================
// Module : greycode_burst_arbiter
// Brief  : Round-robin arbiter streaming L-beat Gray-code bursts per grant.
//          Optional binary output enabled by GREYCODE_ARB_BIN_OUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module greycode_burst_arbiter
  import greycode_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int LEN_W = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  greycode_burst_arbiter_if.slave  bus
);

  localparam int c_id_w = id_width(NREQ);

  state_t              r_state;
  logic [NREQ-1:0]     r_gnt;
  logic                r_busy;
  logic [WIDTH-1:0]    r_count;
  logic [c_id_w-1:0]   r_id;
  logic [c_id_w-1:0]   r_ptr;
  logic                r_out_valid;
  logic                r_done;
  logic [LEN_W-1:0]    r_rem;

  logic [NREQ-1:0]     w_win_onehot;
  logic [c_id_w-1:0]   w_win_idx;
  logic                w_any;
  logic [LEN_W-1:0]    w_win_len;
  logic [WIDTH-1:0]    w_count_next;
  logic [c_id_w-1:0]   w_ptr_next;

  greycode_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (c_id_w)
  ) u_rr (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_winner (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_any    (w_any)
  );

  assign w_win_len    = bus.req_len[int'(w_win_idx)*LEN_W +: LEN_W];
  assign w_count_next = WIDTH'(gray_next(32'(r_count), WIDTH));
  assign w_ptr_next   = (r_id == c_id_w'(NREQ - 1)) ? '0 : r_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_busy      <= 1'b0;
      r_count     <= '0;
      r_id        <= '0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_rem       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_any) begin
            r_gnt   <= w_win_onehot;
            r_id    <= w_win_idx;
            r_busy  <= 1'b1;
            r_count <= '0;
            r_rem   <= w_win_len;
            // Zero-length bursts skip straight to the completion cycle.
            if (w_win_len != '0) begin
              r_state     <= ST_RUN;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (r_out_valid && bus.out_ready) begin
            r_count <= w_count_next;
            r_rem   <= r_rem - 1'b1;
            if (r_rem == LEN_W'(1)) begin
              r_state     <= ST_FIN;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          r_done  <= 1'b0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= w_ptr_next;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_gnt       <= '0;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.busy      = r_busy;
  assign bus.grey_out  = r_count;
  assign bus.out_id    = r_id;
  assign bus.out_valid = r_out_valid;
  assign bus.done      = r_done;

`ifdef GREYCODE_ARB_BIN_OUT_EN
  assign bus.bin_out = r_out_valid ? WIDTH'(gray2bin(32'(r_count))) : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_greycode_burst_arbiter.sv
// ============================================================================
// Module : tb_greycode_burst_arbiter
// Brief  : Directed and randomized bursts checked against a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_greycode_burst_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int LEN_W = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  greycode_burst_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .LEN_W(LEN_W)) bus ();

  greycode_burst_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int ptr_m   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int gray_of(input int k);
    int b;
    b = k % (1 << WIDTH);
    return b ^ (b >> 1);
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_len(input int i, input int l);
    bus.req_len[i*LEN_W +: LEN_W] = LEN_W'(l);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready pattern 1,0,0,1,1 then high
  task automatic run_burst(input int mode);
    int id, len, beats, cnt;
    logic rdy;
    logic [4:0] pat;
    pat = 5'b11001;
    id  = pick(bus.req);
    len = (id < 0) ? 0 : int'(bus.req_len[id*LEN_W +: LEN_W]);
    cyc();
    chk("grant_gnt", 32'(bus.gnt), 32'(1 << id));
    chk("grant_busy", 32'(bus.busy), 32'd1);
    chk("grant_id", 32'(bus.out_id), 32'(id));
    beats = 0;
    cnt   = 0;
    while (beats < len && cnt < 4 * len + 16) begin
      chk("beat_valid", 32'(bus.out_valid), 32'd1);
      chk("beat_grey", 32'(bus.grey_out), 32'(gray_of(beats)));
      chk("beat_id", 32'(bus.out_id), 32'(id));
      chk("beat_gnt", 32'(bus.gnt), 32'(1 << id));
      chk("beat_done", 32'(bus.done), 32'd0);
`ifdef GREYCODE_ARB_BIN_OUT_EN
      chk("beat_bin", 32'(bus.bin_out), 32'(beats % (1 << WIDTH)));
`endif
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cnt < 5) ? pat[cnt] : 1'b1;
      endcase
      bus.out_ready = rdy;
      bus.req       = NREQ'($urandom);
      bus.req_len   = (NREQ*LEN_W)'({$urandom, $urandom});
      cyc();
      if (rdy) beats++;
      cnt++;
    end
    chk("beat_count", 32'(beats), 32'(len));
    chk("fin_done", 32'(bus.done), 32'd1);
    chk("fin_valid", 32'(bus.out_valid), 32'd0);
    chk("fin_gnt", 32'(bus.gnt), 32'(1 << id));
    chk("fin_busy", 32'(bus.busy), 32'd1);
`ifdef GREYCODE_ARB_BIN_OUT_EN
    chk("fin_bin", 32'(bus.bin_out), 32'd0);
`endif
    bus.out_ready = 1'($urandom_range(0, 1));
    cyc();
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_gnt", 32'(bus.gnt), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_valid", 32'(bus.out_valid), 32'd0);
    ptr_m = (id + 1) % NREQ;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_grey"}, 32'(bus.grey_out), 32'd0);
    chk({tag, "_id"}, 32'(bus.out_id), 32'd0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req       = '0;
    bus.req_len   = '0;
    bus.out_ready = 1'b0;
    repeat (2) cyc();
    chk_all_zero("reset");
    rst_n = 1'b1;
    cyc();

    // All requesters, length 1, held: grants rotate 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    for (int k = 0; k < 5; k++) begin
      bus.req = 4'b1111;
      for (int i = 0; i < NREQ; i++) set_len(i, 1);
      chk("rr_order", 32'(pick(bus.req)), 32'(k % NREQ));
      run_burst(0);
    end

    // Single requester, length 5, full ready
    bus.req = 4'b0001;
    set_len(0, 5);
    run_burst(0);

    // Ready toggling 1,0,0,1,1 with length 3
    bus.req = 4'b0001;
    set_len(0, 3);
    run_burst(2);

    // Zero-length burst on requester 2, then requester 3 must win
    bus.req = 4'b0100;
    set_len(2, 0);
    run_burst(0);
    bus.req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_len(i, 2);
    chk("after_zero_pick", 32'(pick(bus.req)), 32'd3);
    run_burst(1);

    // Wrap-around past 2^WIDTH codes
    bus.req = 4'b0010;
    set_len(1, 260);
    run_burst(0);

    // Reset during the third beat
    bus.req = 4'b0001;
    set_len(0, 5);
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("pre_reset_grey", 32'(bus.grey_out), 32'(gray_of(2)));
    bus.req = '0;
    rst_n   = 1'b0;
    #1;
    chk_all_zero("async_reset");
    cyc();
    chk_all_zero("held_reset");
    rst_n = 1'b1;
    ptr_m = 0;
    cyc();
    bus.req = 4'b0001;
    set_len(0, 4);
    run_burst(0);

    // Randomized bursts
    for (int n = 0; n < 25; n++) begin
      bus.req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) set_len(i, int'($urandom_range(0, 9)));
      run_burst(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
